// File: rtl/hyperbus_trans_sched.sv
// HyperBus transaction scheduler: round-robin arbitration over the front-end requesters,
// chip-select decode, one outstanding PHY transfer, and response routing back to the owner.
module hyperbus_trans_sched #(
    parameter int unsigned NumReq     = 2,
    parameter int unsigned NumChips   = 2,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned ChipSelLsb = 23,
    parameter int unsigned BurstWidth = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumReq-1:0]                    req_valid_i,
    output logic [NumReq-1:0]                    req_ready_o,
    input  logic [NumReq-1:0]                    req_write_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]     req_addr_i,
    input  logic [NumReq-1:0][BurstWidth-1:0]    req_burst_i,
    output logic                                 trans_valid_o,
    input  logic                                 trans_ready_i,
    output logic                                 trans_write_o,
    output logic [AddrWidth-1:0]                 trans_addr_o,
    output logic [BurstWidth-1:0]                trans_burst_o,
    output logic [NumChips-1:0]                  trans_cs_o,
    input  logic                                 phy_rx_valid_i,
    input  logic                                 phy_rx_last_i,
    input  logic                                 phy_rx_error_i,
    input  logic [15:0]                          phy_rx_data_i,
    output logic                                 phy_rx_ready_o,
    input  logic                                 phy_b_valid_i,
    input  logic                                 phy_b_error_i,
    output logic                                 phy_b_ready_o,
    output logic [NumReq-1:0]                    rx_valid_o,
    output logic [NumReq-1:0]                    rx_last_o,
    output logic [NumReq-1:0]                    rx_error_o,
    output logic [15:0]                          rx_data_o,
    input  logic [NumReq-1:0]                    rx_ready_i,
    output logic [NumReq-1:0]                    b_valid_o,
    output logic [NumReq-1:0]                    b_error_o,
    input  logic [NumReq-1:0]                    b_ready_i
);

    localparam int unsigned CsW = (NumChips > 1) ? $clog2(NumChips) : 1;
    localparam int unsigned RrW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [AddrWidth-1:0] LocalMask = AddrWidth'((64'd1 << ChipSelLsb) - 64'd1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StErr} state_e;

    state_e                state_q, state_d;
    logic [RrW-1:0]        rr_q, rr_d;
    logic [RrW-1:0]        gnt_q, gnt_d;
    logic                  write_q, write_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [BurstWidth-1:0] burst_q, burst_d;
    logic [NumChips-1:0]   cs_q, cs_d;

    logic                  found;
    logic [RrW-1:0]        win;
    logic [RrW-1:0]        cand;
    logic [AddrWidth-1:0]  win_addr;
    logic [CsW-1:0]        chip_idx;
    logic                  decode_ok;
    logic                  done;

    // Cyclic search starting at rr_q; the first valid requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            cand = RrW'((int'(rr_q) + i) % int'(NumReq));
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign win_addr  = req_addr_i[win];
    assign chip_idx  = win_addr[ChipSelLsb +: CsW];
    assign decode_ok = (32'(chip_idx) < NumChips) && (req_burst_i[win] != '0);

    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        gnt_d          = gnt_q;
        write_d        = write_q;
        addr_d         = addr_q;
        burst_d        = burst_q;
        cs_d           = cs_q;
        done           = 1'b0;
        req_ready_o    = '0;
        phy_rx_ready_o = 1'b0;
        phy_b_ready_o  = 1'b0;
        rx_valid_o     = '0;
        rx_last_o      = '0;
        rx_error_o     = '0;
        rx_data_o      = '0;
        b_valid_o      = '0;
        b_error_o      = '0;
        case (state_q)
            StIdle: begin
                if (found) begin
                    req_ready_o[win] = 1'b1;
                    gnt_d   = win;
                    write_d = req_write_i[win];
                    addr_d  = win_addr & LocalMask;
                    burst_d = req_burst_i[win];
                    if (decode_ok) begin
                        cs_d    = NumChips'(1) << chip_idx;
                        state_d = StIssue;
                    end else begin
                        cs_d    = '0;
                        state_d = StErr;
                    end
                end
            end
            StIssue: begin
                if (trans_ready_i) state_d = StWait;
            end
            StWait: begin
                phy_rx_ready_o    = rx_ready_i[gnt_q];
                phy_b_ready_o     = b_ready_i[gnt_q];
                rx_valid_o[gnt_q] = phy_rx_valid_i;
                rx_last_o[gnt_q]  = phy_rx_last_i;
                rx_error_o[gnt_q] = phy_rx_error_i;
                rx_data_o         = phy_rx_data_i;
                b_valid_o[gnt_q]  = phy_b_valid_i;
                b_error_o[gnt_q]  = phy_b_error_i;
                done = write_q ? (phy_b_valid_i & b_ready_i[gnt_q])
                               : (phy_rx_valid_i & rx_ready_i[gnt_q] & phy_rx_last_i);
            end
            StErr: begin
                // Local error answer; the PHY never sees this request.
                if (write_q) begin
                    b_valid_o[gnt_q] = 1'b1;
                    b_error_o[gnt_q] = 1'b1;
                    done = b_ready_i[gnt_q];
                end else begin
                    rx_valid_o[gnt_q] = 1'b1;
                    rx_last_o[gnt_q]  = 1'b1;
                    rx_error_o[gnt_q] = 1'b1;
                    done = rx_ready_i[gnt_q];
                end
            end
            default: state_d = StIdle;
        endcase
        if (done) begin
            state_d = StIdle;
            rr_d    = (gnt_q == RrW'(NumReq - 1)) ? '0 : gnt_q + RrW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            rr_q    <= '0;
            gnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            burst_q <= '0;
            cs_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            cs_q    <= cs_d;
        end
    end

    assign trans_valid_o = (state_q == StIssue);
    assign trans_write_o = write_q;
    assign trans_addr_o  = addr_q;
    assign trans_burst_o = burst_q;
    assign trans_cs_o    = cs_q;

    a_no_stray_phy_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q != StWait) |-> !(phy_rx_valid_i || phy_b_valid_i));

endmodule

// File: tb/tb_hyperbus_trans_sched.sv
// Directed bench for hyperbus_trans_sched; three chips so an out-of-range chip index is reachable.
module tb_hyperbus_trans_sched;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic [1:0]       req_valid_i = '0;
    logic [1:0]       req_ready_o;
    logic [1:0]       req_write_i = '0;
    logic [1:0][31:0] req_addr_i = '0;
    logic [1:0][15:0] req_burst_i = '0;
    logic             trans_valid_o;
    logic             trans_ready_i = 1'b0;
    logic             trans_write_o;
    logic [31:0]      trans_addr_o;
    logic [15:0]      trans_burst_o;
    logic [2:0]       trans_cs_o;
    logic             phy_rx_valid_i = 1'b0;
    logic             phy_rx_last_i = 1'b0;
    logic             phy_rx_error_i = 1'b0;
    logic [15:0]      phy_rx_data_i = '0;
    logic             phy_rx_ready_o;
    logic             phy_b_valid_i = 1'b0;
    logic             phy_b_error_i = 1'b0;
    logic             phy_b_ready_o;
    logic [1:0]       rx_valid_o, rx_last_o, rx_error_o;
    logic [15:0]      rx_data_o;
    logic [1:0]       rx_ready_i = '0;
    logic [1:0]       b_valid_o, b_error_o;
    logic [1:0]       b_ready_i = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    hyperbus_trans_sched #(
        .NumReq(2), .NumChips(3), .AddrWidth(32), .ChipSelLsb(23), .BurstWidth(16)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_burst_i(req_burst_i),
        .trans_valid_o(trans_valid_o), .trans_ready_i(trans_ready_i),
        .trans_write_o(trans_write_o), .trans_addr_o(trans_addr_o),
        .trans_burst_o(trans_burst_o), .trans_cs_o(trans_cs_o),
        .phy_rx_valid_i(phy_rx_valid_i), .phy_rx_last_i(phy_rx_last_i),
        .phy_rx_error_i(phy_rx_error_i), .phy_rx_data_i(phy_rx_data_i),
        .phy_rx_ready_o(phy_rx_ready_o),
        .phy_b_valid_i(phy_b_valid_i), .phy_b_error_i(phy_b_error_i),
        .phy_b_ready_o(phy_b_ready_o),
        .rx_valid_o(rx_valid_o), .rx_last_o(rx_last_o), .rx_error_o(rx_error_o),
        .rx_data_o(rx_data_o), .rx_ready_i(rx_ready_i),
        .b_valid_o(b_valid_o), .b_error_o(b_error_o), .b_ready_i(b_ready_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        #1;
        chk("rst_trans_valid", 64'(trans_valid_o), 64'd0);
        chk("rst_trans_payload", {trans_write_o, trans_addr_o, trans_burst_o, trans_cs_o}, 64'd0);
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_rsp", {rx_valid_o, rx_last_o, rx_error_o, rx_data_o, b_valid_o, b_error_o}, 64'd0);
        rst_ni = 1'b1;
        tick();

        // Req0 read, chip 0, burst 4
        req_valid_i = 2'b01; req_write_i = 2'b00;
        req_addr_i[0] = 32'h0000_0010; req_burst_i[0] = 16'd4;
        #1 chk("t1_grant", 64'(req_ready_o), 64'b01);
        tick();
        req_valid_i = '0;
        #1;
        chk("t1_trans_valid", 64'(trans_valid_o), 64'd1);
        chk("t1_cs", 64'(trans_cs_o), 64'b001);
        chk("t1_addr", 64'(trans_addr_o), 64'h10);
        chk("t1_burst_wr", {trans_burst_o, trans_write_o}, {16'd4, 1'b0});
        trans_ready_i = 1'b1;
        tick();
        trans_ready_i = 1'b0;
        rx_ready_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            phy_rx_valid_i = 1'b1;
            phy_rx_data_i  = 16'hA0 + 16'(k);
            phy_rx_last_i  = (k == 3);
            #1;
            chk("t1_rx_valid", 64'(rx_valid_o), 64'b01);
            chk("t1_rx_last", 64'(rx_last_o), (k == 3) ? 64'b01 : 64'b00);
            chk("t1_rx_data", 64'(rx_data_o), 64'hA0 + 64'(k));
            chk("t1_phy_rx_ready", 64'(phy_rx_ready_o), 64'd1);
            tick();
        end
        phy_rx_valid_i = 1'b0; phy_rx_last_i = 1'b0; phy_rx_data_i = '0;
        rx_ready_i = '0;
        #1;
        chk("t1_idle_rx_valid", 64'(rx_valid_o), 64'd0);
        chk("t1_idle_phy_ready", 64'(phy_rx_ready_o), 64'd0);

        // Req1 write to chip 1, B held back by the requester
        req_valid_i = 2'b10; req_write_i = 2'b10;
        req_addr_i[1] = 32'h0080_0000; req_burst_i[1] = 16'd2;
        #1 chk("t2_grant", 64'(req_ready_o), 64'b10);
        tick();
        req_valid_i = '0;
        #1;
        chk("t2_cs", 64'(trans_cs_o), 64'b010);
        chk("t2_addr", 64'(trans_addr_o), 64'd0);
        chk("t2_valid_wr", {trans_valid_o, trans_write_o}, 64'b11);
        trans_ready_i = 1'b1;
        tick();
        trans_ready_i = 1'b0;
        phy_b_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t2_b_hold", 64'(b_valid_o), 64'b10);
            chk("t2_phy_b_ready_low", 64'(phy_b_ready_o), 64'd0);
            tick();
        end
        b_ready_i = 2'b10;
        #1 chk("t2_phy_b_ready", 64'(phy_b_ready_o), 64'd1);
        tick();
        phy_b_valid_i = 1'b0; b_ready_i = '0;
        #1 chk("t2_idle_b", 64'(b_valid_o), 64'd0);

        // Both requesters valid: strict rotation 0,1,0,1,0,1
        req_valid_i = 2'b11; req_write_i = 2'b00;
        req_addr_i[0] = 32'h20; req_addr_i[1] = 32'h20;
        req_burst_i[0] = 16'd1; req_burst_i[1] = 16'd1;
        rx_ready_i = 2'b11;
        for (int g = 0; g < 6; g++) begin
            #1 chk("t3_grant", 64'(req_ready_o), (g % 2 == 0) ? 64'b01 : 64'b10);
            tick();
            chk("t3_no_grant_issue", 64'(req_ready_o), 64'd0);
            trans_ready_i = 1'b1;
            tick();
            trans_ready_i = 1'b0;
            phy_rx_valid_i = 1'b1; phy_rx_last_i = 1'b1;
            #1 chk("t3_rx_route", 64'(rx_valid_o), (g % 2 == 0) ? 64'b01 : 64'b10);
            tick();
            phy_rx_valid_i = 1'b0; phy_rx_last_i = 1'b0;
        end
        req_valid_i = '0; rx_ready_i = '0;

        // Undecodable chip index 3, read: local error beat
        req_valid_i = 2'b01; req_write_i = 2'b00;
        req_addr_i[0] = 32'h0180_0000; req_burst_i[0] = 16'd4;
        #1 chk("t4_grant", 64'(req_ready_o), 64'b01);
        tick();
        req_valid_i = '0;
        #1;
        chk("t4_no_trans", 64'(trans_valid_o), 64'd0);
        chk("t4_err_beat", {rx_valid_o, rx_last_o, rx_error_o}, 64'b01_01_01);
        chk("t4_err_data", 64'(rx_data_o), 64'd0);
        tick();
        chk("t4_err_hold", {trans_valid_o, rx_valid_o}, 64'b0_01);
        rx_ready_i = 2'b01;
        tick();
        rx_ready_i = '0;
        #1 chk("t4_idle", {rx_valid_o, trans_valid_o}, 64'd0);

        // Burst 0 write from req1: local B error
        req_valid_i = 2'b10; req_write_i = 2'b10;
        req_addr_i[1] = 32'h40; req_burst_i[1] = 16'd0;
        #1 chk("t5_grant", 64'(req_ready_o), 64'b10);
        tick();
        req_valid_i = '0;
        #1;
        chk("t5_b_err", {b_valid_o, b_error_o}, 64'b10_10);
        chk("t5_no_trans", 64'(trans_valid_o), 64'd0);
        b_ready_i = 2'b10;
        tick();
        b_ready_i = '0;

        // Next request stalled 5 cycles by the PHY; payload must hold
        req_valid_i = 2'b01; req_write_i = 2'b01;
        req_addr_i[0] = 32'h0080_1234; req_burst_i[0] = 16'd8;
        #1 chk("t6_grant", 64'(req_ready_o), 64'b01);
        tick();
        req_valid_i = '0; req_addr_i[0] = 32'hFFFF_FFFF; req_burst_i[0] = 16'hFFFF;
        for (int k = 0; k < 5; k++) begin
            #1 chk("t6_stall_payload",
                   {trans_valid_o, trans_write_o, trans_cs_o, trans_burst_o, trans_addr_o},
                   {1'b1, 1'b1, 3'b010, 16'd8, 32'h1234});
            tick();
        end
        trans_ready_i = 1'b1;
        tick();
        trans_ready_i = 1'b0;
        b_ready_i = 2'b01;
        #1 chk("t6_wait_b_ready", 64'(phy_b_ready_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_trans", {trans_valid_o, trans_write_o, trans_cs_o, trans_burst_o, trans_addr_o}, 64'd0);
        chk("t6_rst_phy_ready", {phy_b_ready_o, phy_rx_ready_o}, 64'd0);
        chk("t6_rst_rsp", {rx_valid_o, b_valid_o, rx_data_o, req_ready_o}, 64'd0);
        b_ready_i = '0;
        tick();
        rst_ni = 1'b1;
        tick();
        req_valid_i = 2'b11; req_write_i = 2'b00;
        req_addr_i[0] = 32'h0; req_burst_i[0] = 16'd1;
        #1 chk("t6_post_rst_grant", 64'(req_ready_o), 64'b01);
        req_valid_i = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
